// File: rtl/uart_avm_arbiter.sv
// rtl/uart_avm_arbiter.sv - round-robin arbiter sharing one Avalon-MM UART slave between two clients
module uart_avm_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 64
) (
  input  logic              avm_clk,
  input  logic              avm_rst,

  input  logic [ADDR_W-1:0] c0_address,
  input  logic              c0_read,
  input  logic              c0_write,
  input  logic [DATA_W-1:0] c0_writedata,
  input  logic              c0_lock,
  output logic [DATA_W-1:0] c0_readdata,
  output logic              c0_waitrequest,

  input  logic [ADDR_W-1:0] c1_address,
  input  logic              c1_read,
  input  logic              c1_write,
  input  logic [DATA_W-1:0] c1_writedata,
  input  logic              c1_lock,
  output logic [DATA_W-1:0] c1_readdata,
  output logic              c1_waitrequest,

  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,

  output logic [1:0]        o_grant,
  output logic              o_busy
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_G0   = 2'd1,
    S_G1   = 2'd2
  } state_t;

  state_t        state;
  logic          rr_last;
  logic [HW-1:0] hold_cnt;

  logic req0;
  logic req1;
  logic cur_is1;
  logic cur_req;
  logic cur_lock;
  logic oth_req;
  logic wd_expired;
  logic done;
  logic release_now;
  logic [HW-1:0] hold_next;

  assign req0 = c0_read | c0_write;
  assign req1 = c1_read | c1_write;

  // Select the granted client's request/lock and evaluate the release condition
  always_comb begin
    cur_is1     = (state == S_G1);
    cur_req     = cur_is1 ? req1 : req0;
    cur_lock    = cur_is1 ? c1_lock : c0_lock;
    oth_req     = cur_is1 ? req0 : req1;
    wd_expired  = (hold_cnt == HOLD_MAX);
    done        = cur_req & ~avm_waitrequest;
    // A stalled transfer (cur_req & waitrequest) can never satisfy either term
    release_now = (done & (~cur_lock | wd_expired)) | (~cur_req & (~cur_lock | wd_expired));
    hold_next   = wd_expired ? hold_cnt : hold_cnt + 1'b1;
  end

  // Grant state machine with round-robin pointer and hold watchdog counter
  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      state    <= S_IDLE;
      rr_last  <= 1'b1;
      hold_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          hold_cnt <= '0;
          if (req0 && req1) begin
            state   <= rr_last ? S_G0 : S_G1;
            rr_last <= ~rr_last;
          end else if (req0) begin
            state   <= S_G0;
            rr_last <= 1'b0;
          end else if (req1) begin
            state   <= S_G1;
            rr_last <= 1'b1;
          end
        end
        S_G0, S_G1: begin
          if (release_now) begin
            hold_cnt <= '0;
            if (oth_req) begin
              // Zero-idle hand-over to the other client
              state   <= cur_is1 ? S_G0 : S_G1;
              rr_last <= ~cur_is1;
            end else if (!(cur_req && done)) begin
              state <= S_IDLE;
            end
          end else begin
            hold_cnt <= hold_next;
          end
        end
        default: begin
          state    <= S_IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  assign o_grant = {state == S_G1, state == S_G0};
  assign o_busy  = (state != S_IDLE);

  // Route the granted client to the slave; the ungranted client is held off
  always_comb begin
    avm_address    = '0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_writedata  = '0;
    c0_readdata    = '0;
    c0_waitrequest = 1'b1;
    c1_readdata    = '0;
    c1_waitrequest = 1'b1;
    if (state == S_G0) begin
      avm_address    = c0_address;
      avm_read       = c0_read;
      avm_write      = c0_write;
      avm_writedata  = c0_writedata;
      c0_readdata    = avm_readdata;
      c0_waitrequest = avm_waitrequest;
    end else if (state == S_G1) begin
      avm_address    = c1_address;
      avm_read       = c1_read;
      avm_write      = c1_write;
      avm_writedata  = c1_writedata;
      c1_readdata    = avm_readdata;
      c1_waitrequest = avm_waitrequest;
    end
  end

endmodule
